// File: rtl/mul8_shift_add_seq.sv
// Sequential unsigned shift-and-add multiplier that drives one external WIDTH-bit adder.
// Optional `MUL_EARLY_TERM_EN`: finish early once the remaining multiplier bits are all zero.
module mul8_shift_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 busy,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready and out_valid are decoded from the state register only.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WIDTH-1:0]    m;
  logic [WIDTH-1:0]    acc_hi;
  logic [WIDTH-1:0]    q;
  logic [CW-1:0]       cnt;
  logic                last_step;
  logic                early;
  logic [2*WIDTH-1:0]  step_val;

  assign add_a     = acc_hi;
  assign add_b     = q[0] ? m : '0;
  assign add_cin   = 1'b0;
  assign out_prod  = {acc_hi, q};
  assign last_step = (cnt == CW'(WIDTH - 1));

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0]    live_mask;
  logic [2*WIDTH-1:0]  skip_val;

  // q[WIDTH-1-cnt:0] still holds unconsumed multiplier bits.
  assign live_mask = {WIDTH{1'b1}} >> cnt;
  assign early     = ((q & live_mask) == '0);
  assign skip_val  = {acc_hi, q} >> (CW'(WIDTH) - cnt);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    // The adder carry lands in the accumulator MSB after the right shift.
    step_val = {add_cout, add_s, q[WIDTH-1:1]};
`ifdef MUL_EARLY_TERM_EN
    if (early) step_val = skip_val;
`endif
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_step || early) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      m      <= '0;
      acc_hi <= '0;
      q      <= '0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            m      <= in_a;
            q      <= in_b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          {acc_hi, q} <= step_val;
          cnt         <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_shift_add_seq.sv
// Self-checking bench for mul8_shift_add_seq with a behavioural adder and product/latency model.
module tb_mul8_shift_add_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           busy;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_s;
  logic           add_cout;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] exp_q[$];

  mul8_shift_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  // External ripple adder, modelled behaviourally.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: number of calculation cycles for a given multiplier.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int hi;
    if (b == 0) return 1;
    hi = 0;
    for (int i = 0; i < W; i++) if (b[i]) hi = i;
    return (hi + 2 > W) ? W : hi + 2;
`else
    return (b == b) ? W : W;
`endif
  endfunction

  // Issue one operation, wait for the product, check latency and value, then release it.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int lat;
    logic [2*W-1:0] e;
    exp_q.push_back(16'(a) * 16'(b));
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(b)));
    e = exp_q.pop_front();
    chk({tag, "_prod"}, 32'(out_prod), 32'(e));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [2*W-1:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_prod", 32'(out_prod), 32'd0);
    chk("rst_cin", 32'(add_cin), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    do_op(8'd13, 8'd11, "t13x11");
    do_op(8'd255, 8'd255, "t255x255");
    do_op(8'd0, 8'd200, "t0x200");
    do_op(8'd200, 8'd0, "t200x0");
    do_op(8'd9, 8'd1, "t9x1");
    do_op(8'd1, 8'd128, "t1x128");

    // Back-pressure: hold DONE, pulse in_valid with other operands.
    exp_q.push_back(16'd37 * 16'd5);
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd37; in_b = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    held = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); in_a = 8'd99; in_b = 8'd99;
      @(negedge clk);
      chk("bp_prod", 32'(out_prod), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_no_second", {30'd0, busy, in_ready}, 32'b01);

    // Reset in the middle of a calculation.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd100; in_b = 8'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'd7, 8'd6, "t7x6");

    // Randomized
    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), "rand");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
